// File: rtl/ro_frame_if.sv
// Frame output stream of ro_frame_capture: head frame word plus valid/ready handshake.
interface ro_frame_if #(
    parameter int unsigned N_CH = 8
);
    logic [2*N_CH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ro_frame_capture.sv
// Locks to the clk_64 falling edge, captures one 2-bit bus value per slot, packs N_CH slots
// per frame and queues frames in a first-word-fall-through FIFO with overflow/short-frame flags.
module ro_frame_capture #(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk_ext,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clk_64,
    input  logic [1:0]                   bus_in,
    ro_frame_if.master                   frm,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [7:0]                   frame_cnt,
    output logic                         ovf,
    output logic                         short_err,
    input  logic                         clr_flags
);
    localparam int unsigned DW = 2 * N_CH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [SW-1:0] LastSlot = SW'(N_CH - 1);
    localparam logic [AW:0]   FullLvl  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {StIdle, StCapture} state_e;

    state_e            state_q;
    logic [1:0]        bus_q;
    logic              sync_q;
    logic [SW-1:0]     slot_q;
    logic [DW-1:0]     pack_q;
    logic [DW-1:0]     frame_word;
    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic              marker, done, full, pop, push, drop, short_set;

    // Bus is driven during the clk_ext high phase, so it is sampled on the falling edge.
    always_ff @(negedge clk_ext or posedge rst) begin
        if (rst) bus_q <= 2'b00;
        else     bus_q <= bus_in;
    end

    always_comb begin
        marker    = sync_q & ~clk_64;
        done      = en && (state_q == StCapture) && (slot_q == LastSlot);
        short_set = en && (state_q == StCapture) && !done && marker;
        full      = (fifo_level == FullLvl);
        pop       = frm.out_valid & frm.out_ready;
        push      = done & (~full | pop);
        drop      = done & full & ~pop;
        frame_word = pack_q;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (slot_q == SW'(k)) frame_word[2*k +: 2] = bus_q;
        end
        frm.out_valid = (fifo_level != '0);
        frm.out_data  = frm.out_valid ? mem[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk_ext) begin
        if (push) mem[wr_ptr_q] <= frame_word;
    end

    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            slot_q     <= '0;
            pack_q     <= '0;
            sync_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_level <= '0;
            frame_cnt  <= 8'd0;
            ovf        <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            sync_q <= clk_64;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_level <= fifo_level + (AW + 1)'(push) - (AW + 1)'(pop);
            if (push) frame_cnt <= frame_cnt + 8'd1;
            // A set event in the same cycle as clr_flags keeps the flag set.
            ovf       <= drop | (ovf & ~clr_flags);
            short_err <= short_set | (short_err & ~clr_flags);

            // A marker always restarts capture, including on the completion edge.
            if (!en) begin
                state_q <= StIdle;
                slot_q  <= '0;
            end else if (marker) begin
                state_q <= StCapture;
                slot_q  <= '0;
                pack_q  <= '0;
            end else if (done) begin
                state_q <= StIdle;
                slot_q  <= '0;
            end else if (state_q == StCapture) begin
                pack_q <= frame_word;
                slot_q <= slot_q + SW'(1);
            end
        end
    end
endmodule
